// File: rtl/shift_op_ctrl.sv
// ARM7 shifter-operand sequencer around an external 32-bit rotator.
// Define SHIFT_OP_CTRL_RRX_EN to make immediate ROR #0 perform RRX.
module shift_op_ctrl #(
  parameter int REG_STALL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] op_data,
  input  logic [1:0]  shift_type,
  input  logic        amt_sel,
  input  logic [4:0]  imm_amt,
  input  logic [7:0]  reg_amt,
  input  logic        carry_in,
  output logic [31:0] bs_data,
  output logic [4:0]  bs_amt,
  output logic        bs_dir,
  input  logic [31:0] bs_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_carry
);

  typedef enum logic [1:0] {IDLE, WAIT, EXEC, DONE} state_t;

  localparam logic [1:0] LSL = 2'd0;
  localparam logic [1:0] LSR = 2'd1;
  localparam logic [1:0] ASR = 2'd2;
  localparam logic [1:0] ROR = 2'd3;
  localparam logic [1:0] STALL_LAST = 2'(REG_STALL - 1);

  state_t      state, state_nx;
  logic [31:0] d_q;
  logic [1:0]  t_q;
  logic        sel_q;
  logic [7:0]  a_q;
  logic        c_q;
  logic [1:0]  cnt_q;

  logic        accept, go_wait;
  logic [31:0] s_d;
  logic [1:0]  s_t;
  logic        s_sel;
  logic [7:0]  s_a;
  logic        s_rrx;

  logic [31:0] lmask, rmask, sign;
  logic        imm0, reg0, big, eq32;
  logic [31:0] res_nx;
  logic        cy_nx;

  // Handshake: accept when idle, or when the held result is being taken
  always_comb begin
    req_ready = !rst && (state == IDLE || (state == DONE && res_ready));
  end

  assign accept    = req_valid & req_ready;
  assign go_wait   = amt_sel && (REG_STALL > 0);
  assign res_valid = (state == DONE);

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = go_wait ? WAIT : EXEC;
      WAIT: if (cnt_q == STALL_LAST) state_nx = EXEC;
      EXEC: state_nx = DONE;
      DONE: if (res_ready) begin
        if (accept) state_nx = go_wait ? WAIT : EXEC;
        else state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end

  // Capture the request on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= '0;
      t_q   <= '0;
      sel_q <= 1'b0;
      a_q   <= '0;
      c_q   <= 1'b0;
    end else if (accept) begin
      d_q   <= op_data;
      t_q   <= shift_type;
      sel_q <= amt_sel;
      a_q   <= amt_sel ? reg_amt : {3'b000, imm_amt};
      c_q   <= carry_in;
    end
  end

  // Register-read stall counter
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) cnt_q <= '0;
    else cnt_q <= cnt_q + 2'd1;
  end

  // Operand feeding the rotator: live inputs when entering EXEC directly
  always_comb begin
    s_d   = accept ? op_data : d_q;
    s_t   = accept ? shift_type : t_q;
    s_sel = accept ? amt_sel : sel_q;
    s_a   = accept ? (amt_sel ? reg_amt : {3'b000, imm_amt}) : a_q;
    s_rrx = 1'b0;
`ifdef SHIFT_OP_CTRL_RRX_EN
    s_rrx = !s_sel && s_a == 8'd0 && s_t == ROR;
`endif
  end

  // Rotator controls load on entry to EXEC and hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      bs_data <= '0;
      bs_amt  <= '0;
      bs_dir  <= 1'b0;
    end else if (state_nx == EXEC) begin
      bs_data <= s_d;
      bs_amt  <= s_rrx ? 5'd1 : s_a[4:0];
      bs_dir  <= (s_t != LSL);
    end
  end

  // Mask/fill the rotated word into the ARM shifter operand
  always_comb begin
    lmask  = 32'hFFFF_FFFF << a_q[4:0];
    rmask  = 32'hFFFF_FFFF >> a_q[4:0];
    sign   = {32{d_q[31]}};
    imm0   = !sel_q && a_q == 8'd0;
    reg0   = sel_q && a_q == 8'd0;
    big    = sel_q ? |a_q[7:5] : imm0;
    eq32   = sel_q ? (a_q == 8'd32) : imm0;
    res_nx = d_q;
    cy_nx  = c_q;
    if (!(reg0 || (imm0 && t_q == LSL))) begin
      unique case (t_q)
        LSL: begin
          if (big) begin
            res_nx = '0;
            cy_nx  = eq32 & d_q[0];
          end else begin
            res_nx = bs_out & lmask;
            cy_nx  = bs_out[0];
          end
        end
        LSR: begin
          if (big) begin
            res_nx = '0;
            cy_nx  = eq32 & d_q[31];
          end else begin
            res_nx = bs_out & rmask;
            cy_nx  = bs_out[31];
          end
        end
        ASR: begin
          if (big) begin
            res_nx = sign;
            cy_nx  = d_q[31];
          end else begin
            res_nx = (bs_out & rmask) | (sign & ~rmask);
            cy_nx  = bs_out[31];
          end
        end
        ROR: begin
          if (imm0) begin
`ifdef SHIFT_OP_CTRL_RRX_EN
            res_nx = {c_q, bs_out[30:0]};
            cy_nx  = bs_out[31];
`else
            res_nx = d_q;
            cy_nx  = c_q;
`endif
          end else if (a_q[4:0] == 5'd0) begin
            res_nx = d_q;
            cy_nx  = d_q[31];
          end else begin
            res_nx = bs_out;
            cy_nx  = bs_out[31];
          end
        end
        default: begin
          res_nx = d_q;
          cy_nx  = c_q;
        end
      endcase
    end
  end

  // Result register toward the ALU
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data  <= '0;
      res_carry <= 1'b0;
    end else if (state == EXEC) begin
      res_data  <= res_nx;
      res_carry <= cy_nx;
    end
  end

endmodule

// File: tb/tb_shift_op_ctrl.sv
// Randomized and directed bench for shift_op_ctrl.
// Uses an arithmetic ARM shifter model and a behavioural rotator.
module tb_shift_op_ctrl;

  localparam int STALL = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] op_data = '0;
  logic [1:0]  shift_type = '0;
  logic        amt_sel = 1'b0;
  logic [4:0]  imm_amt = '0;
  logic [7:0]  reg_amt = '0;
  logic        carry_in = 1'b0;
  logic [31:0] bs_data;
  logic [4:0]  bs_amt;
  logic        bs_dir;
  logic [31:0] bs_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_carry;

  int n_cmp = 0;
  int n_bad = 0;

  shift_op_ctrl #(.REG_STALL(STALL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .op_data(op_data), .shift_type(shift_type),
    .amt_sel(amt_sel), .imm_amt(imm_amt),
    .reg_amt(reg_amt), .carry_in(carry_in),
    .bs_data(bs_data), .bs_amt(bs_amt),
    .bs_dir(bs_dir), .bs_out(bs_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry)
  );

  always #5 clk = ~clk;

  // Behavioural rotator
  always_comb begin
    logic [63:0] w;
    w = {bs_data, bs_data};
    if (bs_dir) bs_out = 32'(w >> bs_amt);
    else bs_out = 32'((w << bs_amt) >> 32);
  end

  // ARM shifter-operand reference: {carry, result}
  function automatic logic [32:0] model(
    input logic [31:0] d, input logic [1:0] t, input logic sel,
    input logic [4:0] imm, input logic [7:0] ra, input logic c);
    int n, k;
    logic [31:0] r;
    logic cy;
    n  = sel ? int'(ra) : int'(imm);
    r  = d;
    cy = c;
    if (!sel && n == 0) begin
      case (t)
        2'd1: begin r = 0; cy = d[31]; end
        2'd2: begin r = {32{d[31]}}; cy = d[31]; end
        2'd3: begin
`ifdef SHIFT_OP_CTRL_RRX_EN
          r = {c, d[31:1]}; cy = d[0];
`endif
        end
        default: ;
      endcase
    end else if (n != 0) begin
      case (t)
        2'd0: begin
          if (n < 32) begin r = d << n; cy = d[32-n]; end
          else if (n == 32) begin r = 0; cy = d[0]; end
          else begin r = 0; cy = 0; end
        end
        2'd1: begin
          if (n < 32) begin r = d >> n; cy = d[n-1]; end
          else if (n == 32) begin r = 0; cy = d[31]; end
          else begin r = 0; cy = 0; end
        end
        2'd2: begin
          if (n < 32) begin
            r = $unsigned($signed(d) >>> n); cy = d[n-1];
          end else begin
            r = {32{d[31]}}; cy = d[31];
          end
        end
        default: begin
          k = n % 32;
          if (k == 0) begin r = d; cy = d[31]; end
          else begin r = (d >> k) | (d << (32 - k)); cy = r[31]; end
        end
      endcase
    end
    return {cy, r};
  endfunction

  // Issue one request from IDLE, wait for the result, hold, then release
  task automatic run_op(
    input logic [31:0] d, input logic [1:0] t, input logic sel,
    input logic [4:0] imm, input logic [7:0] ra, input logic c,
    input int hold,
    output logic [31:0] r, output logic cy, output int lat);
    op_data = d; shift_type = t; amt_sel = sel;
    imm_amt = imm; reg_amt = ra; carry_in = c;
    req_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    op_data = $urandom; shift_type = 2'($urandom);
    amt_sel = 1'($urandom); imm_amt = 5'($urandom);
    reg_amt = 8'($urandom); carry_in = 1'($urandom);
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!res_valid) lat = -1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    r = res_data; cy = res_carry;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (res_valid !== 1'b0 || res_data !== 32'h0 || res_carry !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_res: valid=%b data=%h carry=%b want 0/0/0",
               res_valid, res_data, res_carry);
    end
    n_cmp++;
    if (bs_data !== 32'h0 || bs_amt !== 5'h0 || bs_dir !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_bs: data=%h amt=%h dir=%b want 0", bs_data, bs_amt, bs_dir);
    end
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready_in_rst: got %b want 0", req_ready);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_after: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] dd [7];
    logic [1:0]  tt [7];
    logic        ss [7];
    logic [4:0]  ii [7];
    logic [7:0]  rr [7];
    logic        cc [7];
    logic [31:0] er [7];
    logic        ec [7];
    int          el [7];
    logic [31:0] r;
    logic        cy;
    int          lat;
    dd[0]=32'hF000_000F; tt[0]=0; ss[0]=0; ii[0]=4; rr[0]=0;  cc[0]=0; er[0]=32'h0000_00F0; ec[0]=1; el[0]=1;
    dd[1]=32'h8000_0001; tt[1]=1; ss[1]=0; ii[1]=0; rr[1]=0;  cc[1]=0; er[1]=32'h0;         ec[1]=1; el[1]=1;
    dd[2]=32'h8000_0000; tt[2]=2; ss[2]=0; ii[2]=0; rr[2]=0;  cc[2]=0; er[2]=32'hFFFF_FFFF; ec[2]=1; el[2]=1;
    dd[3]=32'h8000_0010; tt[3]=2; ss[3]=1; ii[3]=0; rr[3]=4;  cc[3]=1; er[3]=32'hF800_0001; ec[3]=0; el[3]=1+STALL;
    dd[4]=32'hFFFF_FFFF; tt[4]=0; ss[4]=1; ii[4]=0; rr[4]=33; cc[4]=1; er[4]=32'h0;         ec[4]=0; el[4]=1+STALL;
    dd[5]=32'h8000_0000; tt[5]=3; ss[5]=1; ii[5]=0; rr[5]=32; cc[5]=0; er[5]=32'h8000_0000; ec[5]=1; el[5]=1+STALL;
`ifdef SHIFT_OP_CTRL_RRX_EN
    dd[6]=32'h0000_0001; tt[6]=3; ss[6]=0; ii[6]=0; rr[6]=0;  cc[6]=1; er[6]=32'h8000_0000; ec[6]=1; el[6]=1;
`else
    dd[6]=32'h0000_0001; tt[6]=3; ss[6]=0; ii[6]=0; rr[6]=0;  cc[6]=1; er[6]=32'h0000_0001; ec[6]=1; el[6]=1;
`endif
    for (int i = 0; i < 7; i++) begin
      run_op(dd[i], tt[i], ss[i], ii[i], rr[i], cc[i], 0, r, cy, lat);
      n_cmp++;
      if (r !== er[i] || cy !== ec[i]) begin
        n_bad++;
        $display("FAIL directed_%0d: got %h/%b want %h/%b", i, r, cy, er[i], ec[i]);
      end
      n_cmp++;
      if (lat !== el[i]) begin
        n_bad++;
        $display("FAIL directed_lat_%0d: got %0d want %0d", i, lat, el[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, r;
    logic [1:0]  t;
    logic        sel, c, cy;
    logic [4:0]  imm;
    logic [7:0]  ra;
    logic [32:0] exp;
    int          lat;
    for (int i = 0; i < 80; i++) begin
      d   = $urandom;
      t   = 2'($urandom);
      sel = 1'($urandom);
      c   = 1'($urandom);
      imm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      case ($urandom_range(0, 6))
        0: ra = 8'd0;
        1: ra = 8'd32;
        2: ra = 8'd33;
        3: ra = 8'd31;
        4: ra = 8'(32 * $urandom_range(2, 7));
        default: ra = 8'($urandom);
      endcase
      exp = model(d, t, sel, imm, ra, c);
      run_op(d, t, sel, imm, ra, c, $urandom_range(0, 2), r, cy, lat);
      n_cmp++;
      if ({cy, r} !== exp) begin
        n_bad++;
        $display("FAIL random_%0d t=%0d sel=%b imm=%0d ra=%0d d=%h c=%b: got %b/%h want %b/%h",
                 i, t, sel, imm, ra, d, c, cy, r, exp[32], exp[31:0]);
      end
      n_cmp++;
      if (lat !== (sel ? 1 + STALL : 1)) begin
        n_bad++;
        $display("FAIL random_lat_%0d: got %0d want %0d", i, lat, sel ? 1 + STALL : 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e1, e2;
    int          lat;
    bit          bad;
    e1 = model(32'h1234_5678, 2'd3, 1'b0, 5'd8, 8'd0, 1'b0);
    e2 = model(32'hCAFE_0001, 2'd1, 1'b0, 5'd1, 8'd0, 1'b0);
    op_data = 32'h1234_5678; shift_type = 2'd3; amt_sel = 1'b0;
    imm_amt = 5'd8; carry_in = 1'b0; req_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid !== 1'b1 || {res_carry, res_data} !== e1 || req_ready !== 1'b0)
        bad = 1;
      req_valid = 1'b1;
      op_data = $urandom;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad || res_valid !== 1'b1 || {res_carry, res_data} !== e1) begin
      n_bad++;
      $display("FAIL hold_stable: valid=%b got %b/%h want %b/%h ready=%b",
               res_valid, res_carry, res_data, e1[32], e1[31:0], req_ready);
    end
    op_data = 32'hCAFE_0001; shift_type = 2'd1; amt_sel = 1'b0;
    imm_amt = 5'd1; carry_in = 1'b0; req_valid = 1'b1;
    res_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; res_ready = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_handoff: res_valid got %b want 0", res_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (res_valid !== 1'b1 || {res_carry, res_data} !== e2) begin
      n_bad++;
      $display("FAIL b2b_second: valid=%b got %b/%h want 1 %b/%h",
               res_valid, res_carry, res_data, e2[32], e2[31:0]);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    op_data = 32'h8000_00F0; shift_type = 2'd2; amt_sel = 1'b1;
    reg_amt = 8'd4; carry_in = 1'b1; req_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (res_valid !== 1'b0 || res_data !== 32'h0 || res_carry !== 1'b0 ||
        bs_data !== 32'h0 || bs_amt !== 5'h0 || bs_dir !== 1'b0 || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: v=%b d=%h c=%b bs=%h/%h/%b rdy=%b want all 0",
               res_valid, res_data, res_carry, bs_data, bs_amt, bs_dir, req_ready);
    end
    rst = 1'b0;
    res_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1;
    end
    res_ready = 1'b0;
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL mid_reset_no_result: res_valid seen got 1 want 0");
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_ready: got %b want 1", req_ready);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_op_ctrl.md
# shift_op_ctrl

Sequencing controller for the 32-bit rotate-only barrel shifter in the ARM7 execute stage. It accepts data-processing shifter-operand requests (LSL/LSR/ASR/ROR/RRX, immediate or register-specified amount) over a valid/ready handshake. It drives the external rotator, masks and fills the rotated word to build the ARM shift result and shifter carry-out, and registers the result toward the ALU. Register-specified shifts take configurable extra cycles, matching the ARM7 extra register-read cycle.

## Interface
- REG_STALL, 1, extra wait cycles for register-specified shifts (legal 0..3)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- op_data  in  32  operand (Rm)
- shift_type  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- amt_sel  in  1  0 immediate amount, 1 register amount
- imm_amt  in  5  immediate shift amount
- reg_amt  in  8  Rs[7:0] shift amount
- carry_in  in  1  current CPSR C
- bs_data  out  32  rotator data input
- bs_amt  out  5  rotator amount
- bs_dir  out  1  0 rotate left, 1 rotate right
- bs_out  in  32  rotator result (combinational from bs_*)
- res_valid  out  1  result present
- res_ready  in  1  downstream accepts
- res_data  out  32  shifter operand
- res_carry  out  1  shifter carry-out

## Operation
- States: IDLE, WAIT, EXEC, DONE.
- req_ready = (state==IDLE) | (state==DONE & res_ready); forced 0 while rst high.
- Accept on req_valid & req_ready: latch op_data, shift_type, amt_sel, the amount (imm_amt zero-extended or reg_amt) and carry_in.
- After accept, go to WAIT if amt_sel=1 and REG_STALL>0; otherwise go to EXEC.
- WAIT counts REG_STALL cycles, then goes to EXEC.
- EXEC: bs_data=latched data, bs_amt=n[4:0]; bs_dir=0 for LSL, 1 otherwise. Register res_data/res_carry, then go to DONE.
- DONE: res_valid=1, outputs held stable until res_ready. On res_ready, go to IDLE, or to the accept path if a new request is taken in the same cycle.
- n = effective amount. Immediate 0 is special: LSL #0 gives data, carry_in. LSR #0 means n=32. ASR #0 means n=32. ROR #0 means RRX (see Configuration).
- Register n==0, all types: data, carry_in.
- LSL: 1..31 gives rot-left masked low n bits to 0, C=data[32-n]. 32 gives 0, C=data[0]. >32 gives 0, C=0.
- LSR: 1..31 gives rot-right masked high n bits to 0, C=data[n-1]. 32 gives 0, C=data[31]. >32 gives 0, C=0.
- ASR: 1..31 gives rot-right with high n bits = data[31], C=data[n-1]. ≥32 gives all data[31], C=data[31].
- ROR (register, n≠0): n[4:0]==0 gives data, C=data[31]. Otherwise rotator output, C=res[31].
- Masks are generated from n[4:0] only; the n≥32 cases are decoded from n[7:5] and LSR/ASR #0.

## Timing
- Immediate request accepted at edge t: EXEC in cycle t..t+1, res_valid high from edge t+1. Register request: res_valid from edge t+1+REG_STALL.
- Back-to-back throughput: one immediate op per 2 cycles, because accept is permitted in the DONE cycle that hands off the result.
- The rotator path is combinational within the EXEC cycle; bs_* hold their last value outside EXEC.
- Reset values: state IDLE, res_valid 0, res_data 0, res_carry 0, bs_data 0, bs_amt 0, bs_dir 0, req_ready 0 during rst, then 1.
- Reset mid-operation (WAIT/EXEC/DONE): the pending operation is dropped, no res_valid is produced, and all outputs return to reset values on the next edge.
- req_valid while not ready is ignored, and the request inputs may change freely.
- res_ready while res_valid=0 is ignored.

## Configuration
- SHIFT_OP_CTRL_RRX_EN defined: immediate ROR #0 performs RRX. res_data={carry_in, data[31:1]}, res_carry=data[0]; bs_amt=1, bs_dir=1, and the result bit 31 is replaced.
- Not defined: immediate ROR #0 is treated as no shift, giving data, carry_in. All other behaviour is identical.

## Test plan
- Imm LSL #4, data 0xF000_000F, C=0 -> res 0x0000_00F0, carry 1; res_valid one edge after EXEC.
- Imm LSR #0, data 0x8000_0001 -> res 0, carry 1. Imm ASR #0, data 0x8000_0000 -> 0xFFFF_FFFF, carry 1.
- Reg ASR, reg_amt 0x04, data 0x8000_0010, REG_STALL=1 -> res 0xF800_0001, carry 0, one cycle later than the immediate case. Reg LSL 33 -> 0, carry 0. Reg ROR 32, data 0x8000_0000 -> data, carry 1.
- Imm ROR #0, data 0x0000_0001, C=1 -> with macro 0x8000_0000, carry 1; without macro 0x0000_0001, carry 1.
- Hold res_ready=0 for 5 cycles -> res_valid/res_data stable and req_ready=0. Then a new request in the same cycle res_ready rises -> accepted, no bubble lost.
- Assert rst during WAIT -> no res_valid produced; all outputs 0; req_ready=1 after rst falls.
